// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int unsigned ZERO_ADDR = 0;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array lookup, same-cycle write bypass,
// zero-register forcing and pending-bit lookup.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              pending,
    input  logic                          bypass_en,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             waddr0,
    input  logic [DATA_W-1:0]             wdata0,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             waddr1,
    input  logic [DATA_W-1:0]             wdata1,
    output logic [DATA_W-1:0]             data,
    output logic                          busy
);

    // Port 1 is checked first so it wins when both writers target this address.
    always_comb begin
        data = regs[addr];
        busy = pending[addr];
        if (bypass_en) begin
            if (we1 && (waddr1 == addr)) begin
                data = wdata1;
                busy = 1'b0;
            end else if (we0 && (waddr0 == addr)) begin
                data = wdata0;
                busy = 1'b0;
            end
        end
        if ((ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR))) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised register file with two write ports, N read ports, bypass,
// a per-register pending scoreboard and a sequenced clear sweep.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic                      clr_req,
    output logic                      clr_busy
);

    localparam int DEPTH = int'(depth_of(ADDR_W));

    rf_state_t                      state;
    rf_state_t                      state_next;
    logic [ADDR_W-1:0]              cnt;
    logic [DEPTH-1:0][DATA_W-1:0]   regs;
    logic [DEPTH-1:0]               pending;
    logic                           keep0;
    logic                           keep1;
    logic                           keep_rsv;
    logic                           bypass_en;

    assign keep0     = !((ZERO_REG != 0) && (waddr0 == ADDR_W'(ZERO_ADDR)));
    assign keep1     = !((ZERO_REG != 0) && (waddr1 == ADDR_W'(ZERO_ADDR)));
    assign keep_rsv  = !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR)));
    assign bypass_en = (BYPASS != 0) && (state == RF_IDLE);
    assign clr_busy  = (state == RF_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE:  if (clr_req) state_next = RF_CLEAR;
            RF_CLEAR: if (cnt == ADDR_W'(DEPTH - 1)) state_next = RF_IDLE;
            default:  state_next = RF_IDLE;
        endcase
    end

    // Statement order sets priority: port 1 overrides port 0, reserve overrides write-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs    <= '0;
            pending <= '0;
            cnt     <= '0;
        end else if (state == RF_IDLE) begin
            if (we0 && keep0) regs[waddr0] <= wdata0;
            if (we1 && keep1) regs[waddr1] <= wdata1;
            if (we0) pending[waddr0] <= 1'b0;
            if (we1) pending[waddr1] <= 1'b0;
            if (rsv_valid && keep_rsv) pending[rsv_addr] <= 1'b1;
            if (clr_req) cnt <= '0;
        end else begin
            regs[cnt]    <= '0;
            pending[cnt] <= 1'b0;
            cnt          <= cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs      (regs),
            .pending   (pending),
            .bypass_en (bypass_en),
            .we0       (we0),
            .waddr0    (waddr0),
            .wdata0    (wdata0),
            .we1       (we1),
            .waddr1    (waddr1),
            .wdata1    (wdata1),
            .data      (rd_data[k*DATA_W +: DATA_W]),
            .busy      (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: behavioural model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     we0, we1, rsv_valid, clr_req;
    logic [ADDR_W-1:0]        waddr0, waddr1, rsv_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     clr_busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: architectural register contents, pending set and remaining sweep length.
    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_pend [DEPTH];
    int                m_sweep_left = 0;
    bit                m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] <= '0;
                m_pend[i] <= 1'b0;
            end
            m_sweep_left <= 0;
            m_valid      <= 1'b1;
        end else if (m_sweep_left > 0) begin
            m_regs[DEPTH - m_sweep_left] <= '0;
            m_pend[DEPTH - m_sweep_left] <= 1'b0;
            m_sweep_left <= m_sweep_left - 1;
        end else begin
            if (we0 && waddr0 != 0) m_regs[waddr0] <= wdata0;
            if (we1 && waddr1 != 0) m_regs[waddr1] <= wdata1;
            if (we0) m_pend[waddr0] <= 1'b0;
            if (we1) m_pend[waddr1] <= 1'b0;
            if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] <= 1'b1;
            if (clr_req) m_sweep_left <= DEPTH;
        end
    end

    function automatic void modelRead(input logic [ADDR_W-1:0] a,
                                      output logic [DATA_W-1:0] d, output logic b);
        d = m_regs[a];
        b = m_pend[a];
        if (m_sweep_left == 0) begin
            if (we1 && waddr1 == a) begin
                d = wdata1; b = 1'b0;
            end else if (we0 && waddr0 == a) begin
                d = wdata0; b = 1'b0;
            end
        end
        if (a == 0) begin
            d = '0; b = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        logic [DATA_W-1:0] ed;
        logic              eb;
        if (m_valid) begin
            for (int k = 0; k < NUM_RD; k++) begin
                modelRead(rd_addr[k*ADDR_W +: ADDR_W], ed, eb);
                checkOutput($sformatf("model_rd_data%0d", k), rd_data[k*DATA_W +: DATA_W], ed);
                checkOutput($sformatf("model_rd_busy%0d", k), 32'(rd_busy[k]), 32'(eb));
            end
            checkOutput("model_clr_busy", 32'(clr_busy), 32'(m_sweep_left > 0));
        end
    end

    task automatic applyStimulus(input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                 input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1,
                                 input logic rv, input logic [ADDR_W-1:0] ra, input logic cr);
        @(posedge clk);
        #1;
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        rd_addr = {r1, r0};
        rsv_valid = rv; rsv_addr = ra; clr_req = cr;
    endtask

    task automatic readOnly(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
        applyStimulus(0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 0);
    endtask

    // Runs idle cycles after a clr_req pulse and returns how many had clr_busy high.
    task automatic countSweep(input int cycles, input int inject_at, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < cycles; i++) begin
            if (i == inject_at) applyStimulus(1, 5, 9, 0, 0, 0, 5, 3, 1, 4, 1);
            else readOnly(5'(i), 5'(31 - i));
            @(negedge clk);
            if (clr_busy) busy_cycles++;
        end
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b1;
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        rd_addr = '0; rsv_valid = 0; rsv_addr = 0; clr_req = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < DEPTH; i += 2) begin
            readOnly(5'(i), 5'(i + 1));
            @(negedge clk);
            checkOutput("reset_rd_data0", rd_data[31:0], 32'h0);
            checkOutput("reset_rd_data1", rd_data[63:32], 32'h0);
            checkOutput("reset_rd_busy", 32'(rd_busy), 32'h0);
            checkOutput("reset_clr_busy", 32'(clr_busy), 32'h0);
        end

        applyStimulus(1, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        readOnly(9, 0);
        @(negedge clk);
        checkOutput("write9_read", rd_data[31:0], 32'd5);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("zero_no_bypass", rd_data[31:0], 32'd0);
        readOnly(0, 9);
        @(negedge clk);
        checkOutput("zero_after_write", rd_data[31:0], 32'd0);

        applyStimulus(1, 10, 3, 1, 10, 8, 10, 10, 0, 0, 0);
        @(negedge clk);
        checkOutput("bypass_port1_prio0", rd_data[31:0], 32'd8);
        checkOutput("bypass_port1_prio1", rd_data[63:32], 32'd8);
        readOnly(10, 9);
        @(negedge clk);
        checkOutput("write_port1_wins", rd_data[31:0], 32'd8);

        applyStimulus(0, 0, 0, 0, 0, 0, 8, 0, 1, 8, 0);
        readOnly(8, 0);
        @(negedge clk);
        checkOutput("reserve_busy", 32'(rd_busy[0]), 32'd1);
        applyStimulus(0, 0, 0, 1, 8, 32'h1234, 8, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("busy_bypass_clear", 32'(rd_busy[0]), 32'd0);
        checkOutput("data_bypass_1234", rd_data[31:0], 32'h1234);
        readOnly(8, 0);
        @(negedge clk);
        checkOutput("busy_after_write", 32'(rd_busy[0]), 32'd0);
        checkOutput("data_after_write", rd_data[31:0], 32'h1234);
        applyStimulus(1, 8, 32'h55, 0, 0, 0, 0, 0, 1, 8, 0);
        readOnly(8, 0);
        @(negedge clk);
        checkOutput("reserve_beats_write", 32'(rd_busy[0]), 32'd1);
        checkOutput("write_with_reserve", rd_data[31:0], 32'h55);

        applyStimulus(1, 1, 11, 1, 2, 22, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 33, 0, 0, 0, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1);
        countSweep(40, 5, busy_cnt);
        checkOutput("sweep_length", 32'(busy_cnt), 32'd32);
        checkOutput("sweep_done_idle", 32'(clr_busy), 32'd0);
        for (int i = 0; i < DEPTH; i += 2) begin
            readOnly(5'(i), 5'(i + 1));
            @(negedge clk);
            checkOutput("swept_data0", rd_data[31:0], 32'h0);
            checkOutput("swept_data1", rd_data[63:32], 32'h0);
            checkOutput("swept_busy", 32'(rd_busy), 32'h0);
        end

        applyStimulus(1, 4, 44, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) readOnly(4, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_sweep", 32'(clr_busy), 32'd0);
        applyStimulus(1, 6, 66, 0, 0, 0, 4, 6, 0, 0, 0);
        readOnly(4, 6);
        @(negedge clk);
        checkOutput("reset_cleared_reg", rd_data[31:0], 32'h0);
        checkOutput("write_after_reset", rd_data[63:32], 32'd66);
        applyStimulus(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
        countSweep(40, -1, busy_cnt);
        checkOutput("resweep_length", 32'(busy_cnt), 32'd32);
        readOnly(6, 0);
        @(negedge clk);
        checkOutput("resweep_cleared", rd_data[31:0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
